// File: rtl/svga_text_pkg.sv
// Shared constants, state encoding and ROM address helper for the text-mode
// character fetch path.
package svga_text_pkg;

  localparam int CHAR_W     = 8;
  localparam int GLYPH_ROWS = 16;
  localparam int ROM_AW     = 12;
  localparam int INV_BIT    = 6;
  localparam int ROW_W      = $clog2(GLYPH_ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } line_state_e;

  // Char ROM address: character code in the upper bits, glyph row below.
  function automatic logic [ROM_AW-1:0] glyph_addr(input logic [CHAR_W-1:0] code,
                                                   input logic [ROW_W-1:0]  row);
    return {code, row};
  endfunction

endpackage

// File: rtl/text_row_fetcher_if.sv
// Scanline control, VRAM read port, char ROM port and pixel output bundle
// of the text row fetcher.
interface text_row_fetcher_if #(
  parameter int VADDR_W = 9
);
  import svga_text_pkg::*;

  logic                line_start;
  logic [VADDR_W-1:0]  row_base;
  logic [ROW_W-1:0]    char_row;
  logic                inv_en;

  logic                vram_rd;
  logic [VADDR_W-1:0]  vram_addr;
  logic [CHAR_W-1:0]   vram_data;

  logic [ROM_AW-1:0]   rom_addr;
  logic [CHAR_W-1:0]   rom_data;

  logic                pix;
  logic                pix_valid;
  logic                busy;
  logic                line_done;

  modport master (
    input  line_start, row_base, char_row, inv_en, vram_data, rom_data,
    output vram_rd, vram_addr, rom_addr, pix, pix_valid, busy, line_done
  );

  modport slave (
    output line_start, row_base, char_row, inv_en, vram_data, rom_data,
    input  vram_rd, vram_addr, rom_addr, pix, pix_valid, busy, line_done
  );

endinterface

// File: rtl/text_pix_shifter.sv
// Glyph serialiser: loads one glyph byte, emits it MSB-first with each pixel
// held PIX_REP cycles, and flags the last cycle of the character slot.
module text_pix_shifter
  import svga_text_pkg::*;
#(
  parameter int PIX_REP = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [CHAR_W-1:0] data_i,
  input  logic              inv_i,
  output logic              pix_o,
  output logic              pix_valid_o,
  output logic              slot_end_o
);

  localparam int REP_W = (PIX_REP > 1) ? $clog2(PIX_REP) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(PIX_REP - 1);

  // sreg holds the bits still to be shown; the bit on display lives in pix_q.
  logic [CHAR_W-1:0] sreg_q, sreg_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [2:0]        bit_q, bit_d;
  logic              inv_q, inv_d;
  logic              active_q, active_d;
  logic              pix_q, pix_d;
  logic              valid_q, valid_d;
  logic              pix_tick;

  assign pix_tick    = active_q && (rep_q == REP_LAST);
  assign slot_end_o  = pix_tick && (bit_q == 3'd7);
  assign pix_o       = pix_q;
  assign pix_valid_o = valid_q;

  always_comb begin
    sreg_d   = sreg_q;
    rep_d    = rep_q;
    bit_d    = bit_q;
    inv_d    = inv_q;
    active_d = active_q;
    pix_d    = pix_q;
    valid_d  = valid_q;
    if (load_i) begin
      sreg_d   = {data_i[CHAR_W-2:0], 1'b0};
      inv_d    = inv_i;
      rep_d    = '0;
      bit_d    = 3'd0;
      active_d = 1'b1;
      pix_d    = data_i[CHAR_W-1] ^ inv_i;
      valid_d  = 1'b1;
    end else if (slot_end_o) begin
      // No follow-on glyph: the line has ended, blank the output.
      rep_d    = '0;
      bit_d    = 3'd0;
      active_d = 1'b0;
      pix_d    = 1'b0;
      valid_d  = 1'b0;
    end else if (pix_tick) begin
      rep_d  = '0;
      bit_d  = bit_q + 3'd1;
      sreg_d = {sreg_q[CHAR_W-2:0], 1'b0};
      pix_d  = sreg_q[CHAR_W-1] ^ inv_q;
    end else if (active_q) begin
      rep_d = rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q   <= '0;
      rep_q    <= '0;
      bit_q    <= 3'd0;
      inv_q    <= 1'b0;
      active_q <= 1'b0;
      pix_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      rep_q    <= rep_d;
      bit_q    <= bit_d;
      inv_q    <= inv_d;
      active_q <= active_d;
      pix_q    <= pix_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/text_row_fetcher.sv
// Per-scanline text fetcher: VRAM code read -> char ROM lookup -> glyph
// serialisation, with the next fetch timed to land exactly on the slot boundary.
module text_row_fetcher
  import svga_text_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int PIX_REP = 1,
  parameter int VADDR_W = 9
) (
  input  logic                pixel_clock,
  input  logic                reset_n,
  text_row_fetcher_if.master  bus
);

  localparam int SLOT  = 8 * PIX_REP;
  localparam int CNT_W = $clog2(SLOT);
  // Fetch latency from decision to shifter load is 4 cycles (issue, F0..F2).
  localparam logic [CNT_W-1:0] ISSUE_AT = CNT_W'(SLOT - 5);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT - 1);
  localparam logic [7:0]       COL_END  = 8'(COLS);

  line_state_e         state_q, state_d;
  logic [VADDR_W-1:0]  row_base_q;
  logic [ROW_W-1:0]    char_row_q;
  logic                inv_en_q;
  logic [7:0]          col_q;
  logic                vram_rd_q;
  logic [VADDR_W-1:0]  vram_addr_q;
  logic                code_inv_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic                f1_q, f2_q, f3_q;
  logic [CNT_W-1:0]    slot_cnt_q;
  logic                line_done_q;

  logic                fetch_go;
  logic                done_d;
  logic [VADDR_W-1:0]  fetch_addr;
  logic                slot_end;

  always_comb begin
    state_d    = state_q;
    fetch_go   = 1'b0;
    done_d     = 1'b0;
    fetch_addr = row_base_q + VADDR_W'(col_q);
    unique case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          state_d    = FILL;
          fetch_go   = 1'b1;
          fetch_addr = bus.row_base;
        end
      end
      FILL: begin
        if (f3_q) begin
          state_d = (col_q == COL_END) ? DRAIN : ACTIVE;
        end
      end
      ACTIVE: begin
        if ((slot_cnt_q == ISSUE_AT) && (col_q != COL_END)) begin
          fetch_go = 1'b1;
        end
        if (f3_q && (col_q == COL_END)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (slot_end && !f3_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_done_q <= done_d;
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      row_base_q  <= '0;
      char_row_q  <= '0;
      inv_en_q    <= 1'b0;
      col_q       <= 8'd0;
      vram_rd_q   <= 1'b0;
      vram_addr_q <= '0;
      code_inv_q  <= 1'b0;
      rom_addr_q  <= '0;
      f1_q        <= 1'b0;
      f2_q        <= 1'b0;
      f3_q        <= 1'b0;
      slot_cnt_q  <= '0;
    end else begin
      if ((state_q == IDLE) && bus.line_start) begin
        row_base_q <= bus.row_base;
        char_row_q <= bus.char_row;
        inv_en_q   <= bus.inv_en;
      end
      vram_rd_q <= fetch_go;
      if (fetch_go) begin
        vram_addr_q <= fetch_addr;
        col_q       <= (state_q == IDLE) ? 8'd1 : col_q + 8'd1;
      end
      f1_q <= vram_rd_q;
      f2_q <= f1_q;
      f3_q <= f2_q;
      // Only the inverse-video bit of the code is needed past the ROM lookup.
      if (f1_q) begin
        code_inv_q <= bus.vram_data[INV_BIT];
        rom_addr_q <= glyph_addr(bus.vram_data, char_row_q);
      end
      if (f3_q) begin
        slot_cnt_q <= '0;
      end else if (slot_cnt_q != CNT_MAX) begin
        slot_cnt_q <= slot_cnt_q + CNT_W'(1);
      end
    end
  end

  text_pix_shifter #(
    .PIX_REP (PIX_REP)
  ) u_shifter (
    .clk_i       (pixel_clock),
    .rst_ni      (reset_n),
    .load_i      (f3_q),
    .data_i      (bus.rom_data),
    .inv_i       (inv_en_q & code_inv_q),
    .pix_o       (bus.pix),
    .pix_valid_o (bus.pix_valid),
    .slot_end_o  (slot_end)
  );

  assign bus.vram_rd   = vram_rd_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.line_done = line_done_q;

endmodule

// File: tb/tb_text_row_fetcher.sv
// Scoreboard bench: each line_start pushes the expected VRAM reads, ROM
// addresses, pixel stream and line_done cycle; a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_text_row_fetcher;
  import svga_text_pkg::*;

  typedef struct packed {
    int cyc;
    int id;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  ev_t vq[$];
  ev_t pq[$];
  ev_t dq[$];
  ev_t prq[$];
  ev_t mon_e;

  logic [7:0] vram_mem [512];
  logic [7:0] rom_mem  [4096];

  text_row_fetcher_if #(.VADDR_W(9)) bus_a ();
  text_row_fetcher_if #(.VADDR_W(9)) bus_b ();

  text_row_fetcher #(.COLS(2), .PIX_REP(1), .VADDR_W(9)) dut_a (
    .pixel_clock (clk),
    .reset_n     (rst_n),
    .bus         (bus_a)
  );

  text_row_fetcher #(.COLS(32), .PIX_REP(2), .VADDR_W(9)) dut_b (
    .pixel_clock (clk),
    .reset_n     (rst_n),
    .bus         (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered VRAM and char ROM models
  always @(posedge clk) begin
    if (bus_a.vram_rd) bus_a.vram_data <= vram_mem[bus_a.vram_addr];
    if (bus_b.vram_rd) bus_b.vram_data <= vram_mem[bus_b.vram_addr];
    bus_a.rom_data <= rom_mem[bus_a.rom_addr];
    bus_b.rom_data <= rom_mem[bus_b.rom_addr];
  end

  logic        m_vram_rd, m_pix, m_pix_valid, m_busy, m_line_done;
  logic [8:0]  m_vram_addr;
  logic [11:0] m_rom_addr;
  assign m_vram_rd   = sel ? bus_b.vram_rd   : bus_a.vram_rd;
  assign m_vram_addr = sel ? bus_b.vram_addr : bus_a.vram_addr;
  assign m_rom_addr  = sel ? bus_b.rom_addr  : bus_a.rom_addr;
  assign m_pix       = sel ? bus_b.pix       : bus_a.pix;
  assign m_pix_valid = sel ? bus_b.pix_valid : bus_a.pix_valid;
  assign m_busy      = sel ? bus_b.busy      : bus_a.busy;
  assign m_line_done = sel ? bus_b.line_done : bus_a.line_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m_vram_rd) begin
      if (vq.size() == 0) chk("vram_rd_unexpected", 1, 0);
      else begin
        mon_e = vq.pop_front();
        chk("vram_rd_cycle", cyc, mon_e.cyc);
        chk("vram_addr", 32'(m_vram_addr), mon_e.val);
      end
    end
    if (m_pix_valid) begin
      if (pq.size() == 0) chk("pix_valid_unexpected", 1, 0);
      else begin
        mon_e = pq.pop_front();
        chk("pix_cycle", cyc, mon_e.cyc);
        chk("pix", 32'(m_pix), mon_e.val);
      end
    end else if (m_pix) begin
      chk("pix_when_invalid", 32'(m_pix), 0);
    end
    if (m_line_done) begin
      if (dq.size() == 0) chk("line_done_unexpected", 1, 0);
      else begin
        mon_e = dq.pop_front();
        chk("line_done_cycle", cyc, mon_e.cyc);
      end
    end
    while (prq.size() > 0 && prq[0].cyc == cyc) begin
      mon_e = prq.pop_front();
      if (mon_e.id == 0) chk("rom_addr", 32'(m_rom_addr), mon_e.val);
      else               chk("busy", 32'(m_busy), mon_e.val);
    end
  end

  task automatic push_line(input int t, input int cols, input int rep,
                           input logic [8:0] base, input logic [3:0] row, input logic inv);
    ev_t        e;
    logic [8:0] a;
    logic [7:0] code, g;
    logic [11:0] ga;
    logic       iv;
    int         slot;
    slot = 8 * rep;
    e = '{cyc: t + 1, id: 1, val: 1};
    prq.push_back(e);
    for (int n = 0; n < cols; n++) begin
      a    = base + 9'(n);
      code = vram_mem[a];
      ga   = {code, row};
      g    = rom_mem[ga];
      iv   = inv & code[6];
      e = '{cyc: t + 1 + n * slot, id: 0, val: 32'(a)};
      vq.push_back(e);
      e = '{cyc: t + 3 + n * slot, id: 0, val: 32'(ga)};
      prq.push_back(e);
      for (int b = 0; b < 8; b++) begin
        for (int r = 0; r < rep; r++) begin
          e = '{cyc: t + 5 + n * slot + b * rep + r, id: 0, val: 32'(g[7-b] ^ iv)};
          pq.push_back(e);
        end
      end
    end
    e = '{cyc: t + 5 + cols * slot, id: 0, val: 0};
    dq.push_back(e);
    e = '{cyc: t + 5 + cols * slot, id: 1, val: 0};
    prq.push_back(e);
  endtask

  task automatic drive_start(input logic go, input logic [8:0] base,
                             input logic [3:0] row, input logic inv);
    if (sel) begin
      bus_b.row_base = base; bus_b.char_row = row; bus_b.inv_en = inv; bus_b.line_start = go;
    end else begin
      bus_a.row_base = base; bus_a.char_row = row; bus_a.inv_en = inv; bus_a.line_start = go;
    end
  endtask

  task automatic start_line(input int cols, input int rep, input logic [8:0] base,
                            input logic [3:0] row, input logic inv, output int t);
    @(negedge clk);
    drive_start(1'b1, base, row, inv);
    t = cyc;
    push_line(t, cols, rep, base, row, inv);
    @(negedge clk);
    // Scramble the sampled inputs so a missing latch shows up.
    drive_start(1'b0, ~base, ~row, ~inv);
  endtask

  task automatic wait_line(input int cols, input int rep);
    repeat (cols * 8 * rep + 10) @(negedge clk);
    chk("vram_reads_left", vq.size(), 0);
    chk("pixels_left", pq.size(), 0);
    chk("line_done_left", dq.size(), 0);
    chk("probes_left", prq.size(), 0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_vram_rd"}, 32'(bus_a.vram_rd), 0);
    chk({tag, "_vram_addr"}, 32'(bus_a.vram_addr), 0);
    chk({tag, "_rom_addr"}, 32'(bus_a.rom_addr), 0);
    chk({tag, "_pix"}, 32'(bus_a.pix), 0);
    chk({tag, "_pix_valid"}, 32'(bus_a.pix_valid), 0);
    chk({tag, "_busy"}, 32'(bus_a.busy), 0);
    chk({tag, "_line_done"}, 32'(bus_a.line_done), 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i * 13 + (i >> 4) * 7 + 1);
    for (int i = 0; i < 512; i++) vram_mem[i] = 8'(i * 29 + 5);
    vram_mem[9'h010] = 8'h41;
    vram_mem[9'h011] = 8'h42;
    vram_mem[9'h1FF] = 8'h05;
    vram_mem[9'h000] = 8'h80;
    rom_mem[12'h413] = 8'hA5;
    rom_mem[12'h423] = 8'h3C;
    sel = 1'b0;
    drive_start(1'b0, 9'h0, 4'h0, 1'b0);
    sel = 1'b1;
    drive_start(1'b0, 9'h0, 4'h0, 1'b0);
    sel = 1'b0;

    repeat (3) @(negedge clk);
    chk_zero_a("reset");
    chk("reset_b_busy", 32'(bus_b.busy), 0);
    chk("reset_b_pix_valid", 32'(bus_b.pix_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic line, glyph A5 plain
    start_line(2, 1, 9'h010, 4'd3, 1'b0, t);
    wait_line(2, 1);
    // Same line with inverse video: both codes have bit 6 set
    start_line(2, 1, 9'h010, 4'd3, 1'b1, t);
    wait_line(2, 1);
    // Address wrap; codes without bit 6 are not inverted
    start_line(2, 1, 9'h1FF, 4'd5, 1'b1, t);
    wait_line(2, 1);

    // Second line_start in cycle T+7 must be ignored
    start_line(2, 1, 9'h010, 4'd3, 1'b0, t);
    repeat (6) @(negedge clk);
    drive_start(1'b1, 9'h123, 4'd9, 1'b1);
    @(negedge clk);
    drive_start(1'b0, 9'h000, 4'd0, 1'b0);
    wait_line(2, 1);

    // Reset mid-line at T+10
    start_line(2, 1, 9'h010, 4'd3, 1'b0, t);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_a("async_reset");
    vq.delete();
    pq.delete();
    dq.delete();
    prq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_line(2, 1, 9'h010, 4'd3, 1'b1, t);
    wait_line(2, 1);

    // Wide line with pixel replication on the second instance
    @(negedge clk);
    sel = 1'b1;
    start_line(32, 2, 9'h040, 4'd7, 1'b1, t);
    wait_line(32, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
